// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types, widths and bit-reverse helper for the shift issue block
package shift_pkg;

  localparam int DATA_W  = 64;
  localparam int SHAMT_W = 6;

  typedef enum logic [1:0] {
    OP_SRA = 2'd0,
    OP_SRL = 2'd1,
    OP_SLL = 2'd2,
    OP_RSV = 2'd3
  } shift_op_t;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_mask_gen.sv
// rtl/shift_mask_gen.sv - thermometer mask: bit i set iff i <= 63 - shamt
module shift_mask_gen
  import shift_pkg::*;
(
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  mask
);

  assign mask = {DATA_W{1'b1}} >> shamt;

endmodule

// File: rtl/shift_issue.sv
// rtl/shift_issue.sv - two-stage issue/response wrapper mapping SRA/SRL/SLL onto an arithmetic right-shift core
module shift_issue
  import shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [DATA_W-1:0]  req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [DATA_W-1:0]  core_in,
  output logic [SHAMT_W-1:0] core_shamt,
  input  logic [DATA_W-1:0]  core_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err
);

  logic               s1_valid;
  shift_op_t          s1_op;
  logic [TAG_W-1:0]   s1_tag;
  logic [DATA_W-1:0]  s1_data;
  logic [SHAMT_W-1:0] s1_shamt;

  logic               s2_valid;
  logic [DATA_W-1:0]  s2_data;
  logic [TAG_W-1:0]   s2_tag;
  logic               s2_err;

  logic               s2_free;
  logic               s1_move;
  logic               req_fire;
  logic [DATA_W-1:0]  mask;
  logic [DATA_W-1:0]  s2_next_data;
  logic               s2_next_err;
  shift_op_t          req_op_t;

  assign req_op_t  = shift_op_t'(req_op);
  assign s2_free   = !s2_valid || rsp_ready;
  assign s1_move   = s1_valid && s2_free;
  assign req_ready = !s1_valid || s2_free;
  assign req_fire  = req_valid && req_ready;

  assign core_in    = s1_data;
  assign core_shamt = s1_shamt;

  assign rsp_valid = s2_valid;
  assign rsp_data  = s2_data;
  assign rsp_tag   = s2_tag;
  assign rsp_err   = s2_err;

  shift_mask_gen u_mask (
    .shamt (s1_shamt),
    .mask  (mask)
  );

  // Left shifts ride the right-shift core on a bit-reversed operand; the mask strips sign fill.
  always_comb begin
    s2_next_data = '0;
    s2_next_err  = 1'b0;
    case (s1_op)
      OP_SRA:  s2_next_data = core_result;
      OP_SRL:  s2_next_data = core_result & mask;
      OP_SLL:  s2_next_data = bit_reverse(core_result & mask);
      default: s2_next_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_SRA;
      s1_tag   <= '0;
      s1_data  <= '0;
      s1_shamt <= '0;
    end else if (req_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= req_op_t;
      s1_tag   <= req_tag;
      s1_data  <= (req_op_t == OP_SLL) ? bit_reverse(req_data) : req_data;
      s1_shamt <= req_shamt;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_err   <= 1'b0;
    end else if (s1_move) begin
      s2_valid <= 1'b1;
      s2_data  <= s2_next_data;
      s2_tag   <= s1_tag;
      s2_err   <= s2_next_err;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// tb/tb_shift_issue.sv - randomized and directed self-checking bench for shift_issue
module tb_shift_issue;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_data;
  logic [5:0]  req_shamt;
  logic [3:0]  req_tag;
  logic [63:0] core_in;
  logic [5:0]  core_shamt;
  logic [63:0] core_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;

  int n_checks = 0;
  int n_err    = 0;
  int dut_acc  = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
    bit          vis;
  } item_t;

  item_t q[$];

  shift_issue #(.TAG_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_shamt   (req_shamt),
    .req_tag     (req_tag),
    .core_in     (core_in),
    .core_shamt  (core_shamt),
    .core_result (core_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err)
  );

  // External arithmetic right-shift core
  assign core_result = 64'($signed(core_in) >>> core_shamt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_res(input logic [1:0] op, input logic [63:0] d,
                                          input logic [5:0] s);
    case (op)
      2'd0:    return 64'($signed(d) >>> s);
      2'd1:    return d >> s;
      2'd2:    return d << s;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    bit    ret;
    bit    acc;
    item_t it;
    ret = (q.size() > 0) && q[0].vis && rsp_ready;
    acc = req_valid && ((q.size() < 2) || rsp_ready);
    it.data = exp_res(req_op, req_data, req_shamt);
    it.tag  = req_tag;
    it.err  = (req_op == 2'd3);
    it.vis  = 1'b0;
    @(posedge clk);
    if (rst_n) begin
      if (ret) void'(q.pop_front());
      if (q.size() > 0) q[0].vis = 1'b1;
      if (acc) q.push_back(it);
    end
    #2;
  endtask

  task automatic set_req(input bit v, input logic [1:0] op, input logic [63:0] d,
                         input logic [5:0] s, input logic [3:0] t);
    req_valid = v;
    req_op    = op;
    req_data  = d;
    req_shamt = s;
    req_tag   = t;
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_data", rsp_data, 64'd0);
      end else begin
        chk("req_ready", 64'(req_ready), 64'((q.size() < 2) || rsp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'((q.size() > 0) && q[0].vis));
        if ((q.size() > 0) && q[0].vis) begin
          chk("rsp_data", rsp_data, q[0].data);
          chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
          chk("rsp_err", 64'(rsp_err), 64'(q[0].err));
        end
        if (req_valid && req_ready) dut_acc++;
      end
    end
  end

  initial begin
    int acc0;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_core_in", core_in, 64'd0);
    chk("reset_core_shamt", 64'(core_shamt), 64'd0);
    chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("pin_sra", exp_res(2'd0, 64'h8000_0000_0000_0000, 6'd4), 64'hF800_0000_0000_0000);
    chk("pin_srl", exp_res(2'd1, 64'h8000_0000_0000_0000, 6'd4), 64'h0800_0000_0000_0000);
    chk("pin_sll", exp_res(2'd2, 64'h1, 6'd63), 64'h8000_0000_0000_0000);

    set_req(1'b1, 2'd0, 64'h8000_0000_0000_0000, 6'd4, 4'd1);
    tick();
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    tick();
    chk("sra_lat_valid", 64'(rsp_valid), 64'd1);
    chk("sra_lat_data", rsp_data, 64'hF800_0000_0000_0000);
    tick();

    set_req(1'b1, 2'd1, 64'h8000_0000_0000_0000, 6'd4, 4'd2);
    tick();
    set_req(1'b1, 2'd2, 64'h1, 6'd63, 4'd3);
    tick();
    chk("srl_data", rsp_data, 64'h0800_0000_0000_0000);
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    tick();
    chk("sll_data", rsp_data, 64'h8000_0000_0000_0000);
    tick();

    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 2'(i % 3), {$urandom, $urandom}, 6'($urandom_range(0, 63)), 4'(i));
      if (i >= 2) begin
        chk("b2b_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_tag", 64'(rsp_tag), 64'(i - 2));
      end
      tick();
    end
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    chk("b2b_tag6", 64'(rsp_tag), 64'd6);
    tick();
    chk("b2b_tag7", 64'(rsp_tag), 64'd7);
    tick();
    chk("b2b_empty", 64'(rsp_valid), 64'd0);

    rsp_ready = 1'b0;
    acc0 = dut_acc;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 2'd1, {$urandom, $urandom}, 6'($urandom_range(0, 63)), 4'(8 + i));
      tick();
    end
    chk("stall_accepts", 64'(dut_acc - acc0), 64'd2);
    chk("stall_ready", 64'(req_ready), 64'd0);
    chk("stall_tag", 64'(rsp_tag), 64'd8);
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    rsp_ready = 1'b1;
    tick();
    chk("drain_tag9", 64'(rsp_tag), 64'd9);
    tick();
    chk("drain_empty", 64'(rsp_valid), 64'd0);

    set_req(1'b1, 2'd3, 64'hDEAD_BEEF_1234_5678, 6'd7, 4'd5);
    tick();
    set_req(1'b1, 2'd1, 64'h8000_0000_0000_0000, 6'd4, 4'd6);
    tick();
    chk("rsv_err", 64'(rsp_err), 64'd1);
    chk("rsv_data", rsp_data, 64'd0);
    chk("rsv_tag", 64'(rsp_tag), 64'd5);
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    tick();
    chk("after_rsv_err", 64'(rsp_err), 64'd0);
    chk("after_rsv_data", rsp_data, 64'h0800_0000_0000_0000);
    tick();

    for (int i = 0; i < 1500; i++) begin
      logic [5:0] s;
      case ($urandom_range(0, 3))
        0:       s = 6'd0;
        1:       s = 6'd63;
        default: s = 6'($urandom_range(0, 63));
      endcase
      set_req($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), {$urandom, $urandom}, s,
              4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end

    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 2'd0, {$urandom, $urandom}, 6'd1, 4'(i));
      tick();
    end
    chk("full_before_reset", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    set_req(1'b1, 2'd2, 64'h0000_0000_0000_00F0, 6'd8, 4'd12);
    tick();
    set_req(1'b0, 2'd0, 64'd0, 6'd0, 4'd0);
    tick();
    chk("post_rst_valid", 64'(rsp_valid), 64'd1);
    chk("post_rst_data", rsp_data, 64'h0000_0000_0000_F000);
    chk("post_rst_tag", 64'(rsp_tag), 64'd12);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameter: TAG_W, default 4, width of the request tag carried alongside each shift.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req_valid  input  1  request present.
REQ-005 Port: req_ready  output  1  block accepts the request this cycle.
REQ-006 Port: req_op  input  2  operation select, shift_op_t: SRA=0, SRL=1, SLL=2, 3 reserved.
REQ-007 Port: req_data  input  64  operand.
REQ-008 Port: req_shamt  input  6  shift amount, 0..63.
REQ-009 Port: req_tag  input  TAG_W  opaque tag, returned unchanged.
REQ-010 Port: core_in  output  64  operand driven to the 64-bit arithmetic right-shift core.
REQ-011 Port: core_shamt  output  6  amount driven to the core.
REQ-012 Port: core_result  input  64  combinational core result for core_in/core_shamt.
REQ-013 Port: rsp_valid  output  1  response present.
REQ-014 Port: rsp_ready  input  1  consumer accepts the response.
REQ-015 Port: rsp_data  output  64  shifted result.
REQ-016 Port: rsp_tag  output  TAG_W  tag of the response.
REQ-017 Port: rsp_err  output  1  request used reserved op 3.

Function
REQ-018 Two register stages: S1 (issue register, drives core) and S2 (response register); each stage holds a valid bit.
REQ-019 S1 captures on req_valid && req_ready: core_in = bit-reverse(req_data) for SLL, req_data otherwise; core_shamt = req_shamt; op and tag stored.
REQ-020 S2 captures when S1 valid and S2 free or draining: SRA -> core_result; SRL -> core_result AND mask; SLL -> bit-reverse(core_result AND mask).
REQ-021 mask bit i = 1 iff i <= 63 - shamt(S1), a thermometer decode of the S1 shift amount.
REQ-022 Op 3: S2 data = 0, rsp_err = 1; the request still occupies both stages and is retired in order.
REQ-023 Latency: accepted request appears on rsp_* exactly 2 cycles later when rsp_ready is held high.
REQ-024 Throughput: one request per cycle sustained while rsp_ready = 1.
REQ-025 req_ready = !S1.valid || !S2.valid || rsp_ready (S1 may advance); combinational from state and rsp_ready only, never from req_valid.
REQ-026 S2 advances/clears on rsp_valid && rsp_ready; simultaneous retire of S2, S1->S2 move and new S1 capture in one cycle is required.
REQ-027 rsp_valid = S2.valid; rsp_data/rsp_tag/rsp_err stable while rsp_valid && !rsp_ready.
REQ-028 Full (both stages valid, rsp_ready = 0): req_ready = 0, no state changes.
REQ-029 Empty: rsp_valid = 0; core_in/core_shamt hold last S1 contents (no functional meaning).
REQ-030 shamt = 0: result equals operand for all three ops (mask all ones).
REQ-031 Ordering: responses leave strictly in acceptance order; no request dropped or duplicated.

Reset
REQ-032 rst_n low asynchronously clears S1.valid and S2.valid; rsp_valid = 0, req_ready = 1 immediately.
REQ-033 Data, shamt, op and tag registers reset to 0; core_in = 0, core_shamt = 0, rsp_data = 0, rsp_tag = 0, rsp_err = 0.
REQ-034 Reset mid-operation discards in-flight requests without response; first post-reset request behaves per REQ-023.

Structure
REQ-035 Package shift_pkg holds shift_op_t, data width constant (64), shamt width constant (6) and a bit-reverse function.
REQ-036 One sub-module, shift_mask_gen: 6-bit shamt in, 64-bit thermometer mask out, combinational.
REQ-037 The core is instantiated outside this block; connection only via core_in/core_shamt/core_result.

Verification
REQ-038 SRA data=0x8000_0000_0000_0000, shamt=4 -> rsp_data=0xF800_0000_0000_0000 two cycles later.
REQ-039 SRL same operand, shamt=4 -> 0x0800_0000_0000_0000; SLL data=0x1, shamt=63 -> 0x8000_0000_0000_0000.
REQ-040 Back-to-back 8 requests, tags 0..7, rsp_ready=1 -> 8 responses in consecutive cycles, tags 0..7 in order.
REQ-041 rsp_ready=0 for 5 cycles with requests offered -> exactly 2 accepted, req_ready=0 thereafter, rsp_* stable; release -> both drain in order.
REQ-042 op=3 with tag=5 -> rsp_err=1, rsp_data=0, rsp_tag=5; next valid op unaffected.
REQ-043 rst_n pulsed low with both stages full -> rsp_valid=0 and req_ready=1 during reset, no stale response after release.
